// File: rtl/turf_reg_pkg.sv
// Shared types and constants for the UDP/Xillybus register-bus arbiter.
package turf_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    localparam logic PORT_UDP = 1'b0;
    localparam logic PORT_XIL = 1'b1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/turf_reg_arb_if.sv
// Register access handshake: used both for the requester ports and the shared bus.
interface turf_reg_arb_if #(
    parameter int AW = 28,
    parameter int DW = 32
);
    logic          en;
    logic          wr;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic          ack;
    logic [DW-1:0] rdat;
    logic          err;

    modport master (output en, output wr, output adr, output wdat,
                    input  ack, input  rdat, input  err);
    modport slave  (input  en, input  wr, input  adr, input  wdat,
                    output ack, output rdat, output err);
endinterface

// File: rtl/turf_rr_arb2.sv
// Two-way round-robin grant; the pointer names the port favoured on a tie.
module turf_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic ptr_q;
    logic ptr_d;

    // Winner selection: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = 1'b0;
        if (req_i == 2'b11) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = ptr_q;
        end else if (req_i == 2'b10) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = 1'b1;
        end else if (req_i == 2'b01) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = 1'b0;
        end else begin
            gnt_valid_o = 1'b0;
            gnt_idx_o   = 1'b0;
        end
    end

    // Pointer next state: favour the other port only once a grant is taken.
    always_comb begin
        ptr_d = ptr_q;
        if (take_i && gnt_valid_o) begin
            ptr_d = ~gnt_idx_o;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/turf_reg_arb.sv
// Arbitrates UDP (port 0) and Xillybus (port 1) register requests onto one
// register bus, with a per-transaction ack timeout and an abort counter.
module turf_reg_arb
    import turf_reg_pkg::*;
#(
    parameter int                   ADDR_BITS = 28,
    parameter int                   DATA_BITS = 32,
    parameter int                   TIMEOUT   = 64,
    parameter logic [DATA_BITS-1:0] ERR_DATA  = DATA_BITS'(ERR_DATA_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst,
    turf_reg_arb_if.slave          req0,
    turf_reg_arb_if.slave          req1,
    turf_reg_arb_if.master         bus,
    output logic [7:0]             timeout_cnt_o
);

    state_e                 state_q;
    logic [7:0]             cnt_q;
    logic                   sel_q;
    logic                   bus_en_q;
    logic                   bus_wr_q;
    logic [ADDR_BITS-1:0]   bus_adr_q;
    logic [DATA_BITS-1:0]   bus_dat_q;
    logic                   ack0_q;
    logic                   ack1_q;
    logic [DATA_BITS-1:0]   dat0_q;
    logic [DATA_BITS-1:0]   dat1_q;
    logic                   err0_q;
    logic                   err1_q;
    logic [7:0]             tcnt_q;

    logic                   idle_s;
    logic                   gnt_valid_s;
    logic                   gnt_idx_s;

    assign idle_s = (state_q == ST_IDLE);

    turf_rr_arb2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_i       ({req1.en, req0.en}),
        .take_i      (idle_s),
        .gnt_valid_o (gnt_valid_s),
        .gnt_idx_o   (gnt_idx_s)
    );

    // Transaction FSM: grant, wait for ack or timeout, then pulse the requester's ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            sel_q     <= PORT_UDP;
            bus_en_q  <= 1'b0;
            bus_wr_q  <= 1'b0;
            bus_adr_q <= '0;
            bus_dat_q <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            dat0_q    <= '0;
            dat1_q    <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            tcnt_q    <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    if (gnt_valid_s) begin
                        sel_q    <= gnt_idx_s;
                        bus_en_q <= 1'b1;
                        cnt_q    <= 8'd0;
                        state_q  <= ST_BUSY;
                        if (gnt_idx_s == PORT_XIL) begin
                            bus_wr_q  <= req1.wr;
                            bus_adr_q <= req1.adr;
                            bus_dat_q <= req1.wdat;
                        end else begin
                            bus_wr_q  <= req0.wr;
                            bus_adr_q <= req0.adr;
                            bus_dat_q <= req0.wdat;
                        end
                    end
                end
                ST_BUSY: begin
                    // A same-cycle ack beats the timeout.
                    if (bus.ack) begin
                        bus_en_q <= 1'b0;
                        state_q  <= ST_DONE;
                        if (sel_q == PORT_XIL) begin
                            ack1_q <= 1'b1;
                            err1_q <= 1'b0;
                            if (!bus_wr_q) begin
                                dat1_q <= bus.rdat;
                            end
                        end else begin
                            ack0_q <= 1'b1;
                            err0_q <= 1'b0;
                            if (!bus_wr_q) begin
                                dat0_q <= bus.rdat;
                            end
                        end
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        bus_en_q <= 1'b0;
                        state_q  <= ST_DONE;
                        tcnt_q   <= sat_inc8(tcnt_q);
                        if (sel_q == PORT_XIL) begin
                            ack1_q <= 1'b1;
                            err1_q <= 1'b1;
                            dat1_q <= ERR_DATA;
                        end else begin
                            ack0_q <= 1'b1;
                            err0_q <= 1'b1;
                            dat0_q <= ERR_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    bus_en_q <= 1'b0;
                    ack0_q   <= 1'b0;
                    ack1_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.en        = bus_en_q;
    assign bus.wr        = bus_wr_q;
    assign bus.adr       = bus_adr_q;
    assign bus.wdat      = bus_dat_q;
    assign req0.ack      = ack0_q;
    assign req0.rdat     = dat0_q;
    assign req0.err      = err0_q;
    assign req1.ack      = ack1_q;
    assign req1.rdat     = dat1_q;
    assign req1.err      = err1_q;
    assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_turf_reg_arb.sv
// Directed bench for turf_reg_arb with an in-order completion scoreboard.
module tb_turf_reg_arb;

    typedef struct packed {
        logic        port;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tcnt;
    int          ack_mode;
    logic [31:0] rd_val;
    int          en_cyc;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];

    turf_reg_arb_if #(.AW(28), .DW(32)) req0_if ();
    turf_reg_arb_if #(.AW(28), .DW(32)) req1_if ();
    turf_reg_arb_if #(.AW(28), .DW(32)) bus_if ();

    turf_reg_arb dut (
        .clk           (clk),
        .rst           (rst),
        .req0          (req0_if),
        .req1          (req1_if),
        .bus           (bus_if),
        .timeout_cnt_o (tcnt)
    );

    always #5 clk = ~clk;

    // Register slave: 0 = combinational ack, 1 = never ack, 2 = ack in the 64th bus cycle.
    always_comb begin
        bus_if.ack  = 1'b0;
        bus_if.rdat = rd_val;
        bus_if.err  = 1'b0;
        case (ack_mode)
            0:       bus_if.ack = bus_if.en;
            2:       bus_if.ack = bus_if.en && (en_cyc == 63);
            default: bus_if.ack = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        if (bus_if.en) en_cyc <= en_cyc + 1;
        else           en_cyc <= 0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic pop_check(input logic p, input logic [31:0] d, input logic e);
        exp_t x;
        n_chk++;
        assert (exp_q.size() > 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL sb_empty: ack on port %0d observed, none expected", p);
        end
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("sb_port", {31'd0, p}, {31'd0, x.port});
            chk("sb_dat", d, x.dat);
            chk("sb_err", {31'd0, e}, {31'd0, x.err});
        end
    endtask

    task automatic set_req(input logic p, input logic wr, input logic [27:0] adr,
                           input logic [31:0] wdat);
        if (p) begin
            req1_if.wr = wr; req1_if.adr = adr; req1_if.wdat = wdat; req1_if.en = 1'b1;
        end else begin
            req0_if.wr = wr; req0_if.adr = adr; req0_if.wdat = wdat; req0_if.en = 1'b1;
        end
    endtask

    task automatic push_exp(input logic p, input logic [31:0] d, input logic e);
        exp_t x;
        x.port = p; x.dat = d; x.err = e;
        exp_q.push_back(x);
    endtask

    // Service requesters until every raised request has been acked; counts bus-enable cycles.
    task automatic wait_ack(input int bound, output int ncyc);
        int it;
        ncyc = 0;
        it   = 0;
        while ((req0_if.en || req1_if.en) && it < bound) begin
            @(posedge clk); #1;
            it++;
            chk("no_double_ack", {31'd0, req0_if.ack & req1_if.ack}, 32'd0);
            if (req0_if.ack) begin
                pop_check(1'b0, req0_if.rdat, req0_if.err);
                req0_if.en = 1'b0;
            end
            if (req1_if.ack) begin
                pop_check(1'b1, req1_if.rdat, req1_if.err);
                req1_if.en = 1'b0;
            end
            if (!req0_if.ack && !req1_if.ack && bus_if.en) ncyc++;
        end
        chk("ack_before_bound", {30'd0, req0_if.en, req1_if.en}, 32'd0);
        req0_if.en = 1'b0;
        req1_if.en = 1'b0;
    endtask

    task automatic do_txn(input logic p, input logic wr, input logic [27:0] adr,
                          input logic [31:0] wdat, input logic [31:0] edat,
                          input logic eerr, input int ecyc, input string tag);
        int n;
        set_req(p, wr, adr, wdat);
        push_exp(p, edat, eerr);
        @(posedge clk); #1;
        chk({tag, "_bus_en"}, {31'd0, bus_if.en}, 32'd1);
        chk({tag, "_bus_wr"}, {31'd0, bus_if.wr}, {31'd0, wr});
        chk({tag, "_bus_adr"}, {4'd0, bus_if.adr}, {4'd0, adr});
        if (wr) chk({tag, "_bus_dat"}, bus_if.wdat, wdat);
        wait_ack(400, n);
        chk({tag, "_en_cycles"}, n + 1, ecyc);
        @(posedge clk); #1;
        chk({tag, "_idle_en"}, {31'd0, bus_if.en}, 32'd0);
        chk({tag, "_idle_ack"}, {30'd0, req0_if.ack, req1_if.ack}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ack_mode = 0;
        rd_val = 32'd0;
        req0_if.en = 1'b0; req0_if.wr = 1'b0; req0_if.adr = 28'd0; req0_if.wdat = 32'd0;
        req1_if.en = 1'b0; req1_if.wr = 1'b0; req1_if.adr = 28'd0; req1_if.wdat = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_en", {31'd0, bus_if.en}, 32'd0);
        chk("rst_bus_wr", {31'd0, bus_if.wr}, 32'd0);
        chk("rst_bus_adr", {4'd0, bus_if.adr}, 32'd0);
        chk("rst_bus_dat", bus_if.wdat, 32'd0);
        chk("rst_acks", {30'd0, req0_if.ack, req1_if.ack}, 32'd0);
        chk("rst_dat0", req0_if.rdat, 32'd0);
        chk("rst_dat1", req1_if.rdat, 32'd0);
        chk("rst_errs", {30'd0, req0_if.err, req1_if.err}, 32'd0);
        chk("rst_tcnt", {24'd0, tcnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Tie from reset: port 0 then port 1, twice.
        rd_val = 32'h1111_0035;
        set_req(1'b0, 1'b0, 28'd4, 32'd0);
        set_req(1'b1, 1'b1, 28'd6, 32'h0BAD_0001);
        push_exp(1'b0, 32'h1111_0035, 1'b0);
        push_exp(1'b1, 32'h0000_0000, 1'b0);
        wait_ack(50, n);
        @(posedge clk); #1;
        rd_val = 32'h2222_0035;
        set_req(1'b0, 1'b1, 28'd8, 32'h0BAD_0002);
        set_req(1'b1, 1'b0, 28'd9, 32'd0);
        push_exp(1'b0, 32'h1111_0035, 1'b0);
        push_exp(1'b1, 32'h2222_0035, 1'b0);
        wait_ack(50, n);
        @(posedge clk); #1;

        // Lone port 0 grant moves the pointer; the next tie goes to port 1.
        rd_val = 32'h3333_0022;
        do_txn(1'b0, 1'b0, 28'd3, 32'd0, 32'h3333_0022, 1'b0, 1, "lone0");
        rd_val = 32'h4444_0022;
        set_req(1'b0, 1'b0, 28'd5, 32'd0);
        set_req(1'b1, 1'b0, 28'd7, 32'd0);
        push_exp(1'b1, 32'h4444_0022, 1'b0);
        push_exp(1'b0, 32'h4444_0022, 1'b0);
        wait_ack(50, n);
        @(posedge clk); #1;

        // Basic read with combinational ack.
        rd_val = 32'h1234_5678;
        do_txn(1'b0, 1'b0, 28'd2, 32'd0, 32'h1234_5678, 1'b0, 1, "rd0");

        // Timeout after 64 bus cycles.
        ack_mode = 1;
        do_txn(1'b0, 1'b0, 28'd10, 32'd0, 32'hDEAD_BEEF, 1'b1, 64, "tmo");
        chk("tmo_tcnt", {24'd0, tcnt}, 32'd1);

        // Ack in the 64th cycle wins over the timeout.
        ack_mode = 2;
        rd_val = 32'hA5A5_0037;
        do_txn(1'b1, 1'b0, 28'd11, 32'd0, 32'hA5A5_0037, 1'b0, 64, "late_ack");
        chk("late_ack_tcnt", {24'd0, tcnt}, 32'd1);

        // Reset while a write is outstanding.
        ack_mode = 1;
        set_req(1'b1, 1'b1, 28'd2, 32'hCAFE_F00D);
        @(posedge clk); #1;
        chk("wr_bus_en", {31'd0, bus_if.en}, 32'd1);
        chk("wr_bus_dat", bus_if.wdat, 32'hCAFE_F00D);
        repeat (10) begin
            @(posedge clk); #1;
            chk("wr_no_ack", {30'd0, req0_if.ack, req1_if.ack}, 32'd0);
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bus_en", {31'd0, bus_if.en}, 32'd0);
        chk("mid_rst_bus_wr", {31'd0, bus_if.wr}, 32'd0);
        chk("mid_rst_bus_adr", {4'd0, bus_if.adr}, 32'd0);
        chk("mid_rst_bus_dat", bus_if.wdat, 32'd0);
        chk("mid_rst_acks", {30'd0, req0_if.ack, req1_if.ack}, 32'd0);
        chk("mid_rst_dat0", req0_if.rdat, 32'd0);
        chk("mid_rst_dat1", req1_if.rdat, 32'd0);
        chk("mid_rst_tcnt", {24'd0, tcnt}, 32'd0);
        req1_if.en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ack_mode = 0;
        @(posedge clk); #1;
        chk("post_rst_no_ack", {30'd0, req0_if.ack, req1_if.ack}, 32'd0);
        do_txn(1'b1, 1'b1, 28'd2, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1, "post_rst");

        // Saturating abort counter.
        ack_mode = 1;
        for (int i = 0; i < 300; i++) begin
            do_txn(i[0], 1'b0, 28'(i), 32'd0, 32'hDEAD_BEEF, 1'b1, 64, "sat");
            if (i == 253) chk("sat_tcnt_254", {24'd0, tcnt}, 32'd254);
            if (i == 254) chk("sat_tcnt_255", {24'd0, tcnt}, 32'd255);
        end
        chk("sat_tcnt_final", {24'd0, tcnt}, 32'd255);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
